// File: rtl/aes_key_round_gen_if.sv
// rtl/aes_key_round_gen_if.sv - start/abort command and round-key stream bundle for aes_key_round_gen
interface aes_key_round_gen_if;
  logic         start;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, abort, rk_ready,
    input  rk_valid, rk_out, rk_round, busy, done
  );

  modport slave (
    input  start, key_in, abort, rk_ready,
    output rk_valid, rk_out, rk_round, busy, done
  );
endinterface

// File: rtl/aes_key_round_gen.sv
// rtl/aes_key_round_gen.sv - sequential AES-128 key schedule, one round key per handshake
module aes_key_round_gen #(
  parameter int LAST_ROUND = 10
) (
  input logic               clk,
  input logic               rst_n,
  aes_key_round_gen_if.slave bus
);

  localparam logic [3:0] LAST = 4'(LAST_ROUND);

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         done_q;
  logic         handshake;
  logic         at_last;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // g-function (RotWord, SubWord, round constant) followed by the word XOR chain.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = t ^ {rcon(r), 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk_valid is exactly "in EMIT", so the handshake needs only the consumer's ready.
  assign handshake = (state == EMIT) && bus.rk_ready;
  assign at_last   = (round_q == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides start and the handshake.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = EMIT;
        EMIT:    if (handshake && at_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.rk_valid = (state == EMIT);
    bus.busy     = (state == EMIT);
  end

  // Key/round register: load on start, advance on each non-final accept, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      round_q <= '0;
    end else if (!bus.abort) begin
      if (state == IDLE && bus.start) begin
        key_q   <= bus.key_in;
        round_q <= '0;
      end else if (handshake && !at_last) begin
        key_q   <= next_key(key_q, round_q + 4'd1);
        round_q <= round_q + 4'd1;
      end
    end
  end

  // One-cycle completion pulse after the final round key is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= !bus.abort && handshake && at_last;
  end

  assign bus.rk_out   = key_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_key_round_gen.sv
// tb/tb_aes_key_round_gen.sv - directed table-driven bench for aes_key_round_gen
module tb_aes_key_round_gen;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam int NV = 14;

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  vec_t         vt [NV];
  logic [127:0] got_key   [11];
  logic [3:0]   got_round [11];
  int           got_n;

  aes_key_round_gen_if bus ();

  aes_key_round_gen #(.LAST_ROUND(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return (cyc % 4) == 0;
  endfunction

  // Start an expansion and collect the 11 accepted keys; checks latency, stability and done timing.
  task automatic run_seq(input logic [127:0] key, input int mode, input bit inject, input string tag);
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    bit           prev_hold;
    int           early_done;
    int           stable_err;
    got_n      = 0;
    early_done = 0;
    stable_err = 0;
    prev_hold  = 0;
    prev_out   = '0;
    prev_round = '0;
    for (int i = 0; i < 11; i++) begin
      got_key[i]   = '0;
      got_round[i] = '0;
    end
    @(negedge clk);
    bus.key_in = key;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_latency_valid"}, {127'd0, bus.rk_valid}, 128'd1);
    chk({tag, "_latency_busy"},  {127'd0, bus.busy}, 128'd1);
    for (int cyc = 0; cyc < 200 && got_n < 11; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (prev_hold && (bus.rk_out !== prev_out || bus.rk_round !== prev_round)) stable_err++;
      if (bus.done) early_done++;
      bus.start = 1'b0;
      if (inject && cyc == 3) begin
        bus.start  = 1'b1;
        bus.key_in = ~key;
      end
      bus.rk_ready = ready_for(mode, cyc);
      if (bus.rk_valid && bus.rk_ready) begin
        got_key[got_n]   = bus.rk_out;
        got_round[got_n] = bus.rk_round;
        got_n++;
      end
      prev_hold  = bus.rk_valid && !bus.rk_ready;
      prev_out   = bus.rk_out;
      prev_round = bus.rk_round;
    end
    bus.start = 1'b0;
    chk({tag, "_count"}, 128'(got_n), 128'd11);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {127'd0, bus.done}, 128'd1);
    chk({tag, "_valid_low"},  {127'd0, bus.rk_valid}, 128'd0);
    chk({tag, "_busy_low"},   {127'd0, bus.busy}, 128'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {127'd0, bus.done}, 128'd0);
    chk({tag, "_no_early_done"},  128'(early_done), 128'd0);
    chk({tag, "_stable_hold"},    128'(stable_err), 128'd0);
    bus.rk_ready = 1'b1;
  endtask

  // Compare collected keys against every table entry for this cipher key.
  task automatic check_table(input logic [127:0] key, input string tag);
    for (int i = 0; i < NV; i++) begin
      if (vt[i].key == key)
        chk($sformatf("%s_key_r%0d", tag, vt[i].round), got_key[vt[i].round], vt[i].exp);
    end
    for (int r = 0; r < 11; r++)
      chk($sformatf("%s_index_%0d", tag, r), {124'd0, got_round[r]}, 128'(r));
  endtask

  initial begin
    int n;
    vt[0]  = '{FIPS_KEY, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vt[1]  = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vt[2]  = '{FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vt[3]  = '{FIPS_KEY, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vt[4]  = '{FIPS_KEY, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vt[5]  = '{FIPS_KEY, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vt[6]  = '{FIPS_KEY, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vt[7]  = '{FIPS_KEY, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vt[8]  = '{FIPS_KEY, 8,  128'head27321b58dbad2312bf5607f8d292f};
    vt[9]  = '{FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
    vt[10] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[11] = '{ZERO_KEY, 0,  128'h00000000000000000000000000000000};
    vt[12] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
    vt[13] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.abort    = 1'b0;
    bus.rk_ready = 1'b1;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rk_out",   bus.rk_out, 128'd0);
    chk("reset_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
    chk("reset_rk_round", {124'd0, bus.rk_round}, 128'd0);
    chk("reset_busy",     {127'd0, bus.busy}, 128'd0);
    chk("reset_done",     {127'd0, bus.done}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_seq(FIPS_KEY, 0, 1'b0, "fips_cont");
    check_table(FIPS_KEY, "fips_cont");

    run_seq(ZERO_KEY, 0, 1'b0, "zero_cont");
    check_table(ZERO_KEY, "zero_cont");

    run_seq(FIPS_KEY, 1, 1'b0, "fips_toggle");
    check_table(FIPS_KEY, "fips_toggle");

    run_seq(FIPS_KEY, 1, 1'b1, "fips_inject");
    check_table(FIPS_KEY, "fips_inject");

    // Abort once round 5 is presented.
    @(negedge clk);
    bus.key_in   = FIPS_KEY;
    bus.start    = 1'b1;
    bus.rk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.rk_round != 4'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_r5", {124'd0, bus.rk_round}, 128'd5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_valid", {127'd0, bus.rk_valid}, 128'd0);
    chk("abort_busy",  {127'd0, bus.busy}, 128'd0);
    chk("abort_done",  {127'd0, bus.done}, 128'd0);
    @(negedge clk);
    chk("abort_no_done_later", {127'd0, bus.done}, 128'd0);
    run_seq(FIPS_KEY, 0, 1'b0, "after_abort");
    check_table(FIPS_KEY, "after_abort");

    // Asynchronous reset while round 3 is presented.
    @(negedge clk);
    bus.key_in = FIPS_KEY;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.rk_round != 4'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_r3", {124'd0, bus.rk_round}, 128'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rk_out",   bus.rk_out, 128'd0);
    chk("midrst_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
    chk("midrst_rk_round", {124'd0, bus.rk_round}, 128'd0);
    chk("midrst_busy",     {127'd0, bus.busy}, 128'd0);
    chk("midrst_done",     {127'd0, bus.done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(FIPS_KEY, 0, 1'b0, "after_rst");
    check_table(FIPS_KEY, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
